// File: rtl/pipe_ctrl.sv
// Five-stage in-order pipeline controller: valid/allowin handshakes, load-use interlock,
// branch redirect with fetch flush, and a stall-cycle counter.
module pipe_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    localparam int unsigned XLEN = 32,
    localparam int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            if_ready_go,
    input  logic            mem_ready_go,
    input  logic            ex_busy,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            ex_is_load,
    input  logic [REGW-1:0] ex_rd,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] pc,
    output logic            if_valid,
    output logic            id_valid,
    output logic            ex_valid,
    output logic            mem_valid,
    output logic            wb_valid,
    output logic            if_to_id_fire,
    output logic            id_to_ex_fire,
    output logic            ex_to_mem_fire,
    output logic            mem_to_wb_fire,
    output logic            flush_if,
    output logic            load_use_stall,
    output logic [XLEN-1:0] stall_cnt
);

    logic id_ready_go;
    logic ex_ready_go;
    logic id_allowin;
    logic ex_allowin;
    logic mem_allowin;
    logic rs1_hit;
    logic rs2_hit;
    logic br_fire;
    logic stall_cycle;

    // Only a load still in EX can interlock; later producers are forwarded.
    assign rs1_hit        = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit        = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use_stall = id_valid && ex_valid && ex_is_load && (ex_rd != '0)
                            && (rs1_hit || rs2_hit);

    assign id_ready_go = !load_use_stall;
    assign ex_ready_go = !ex_busy;

    // WB always accepts, so MEM's allowin depends only on its own progress.
    assign mem_allowin = !mem_valid || mem_ready_go;
    assign ex_allowin  = !ex_valid  || (ex_ready_go && mem_allowin);
    assign id_allowin  = !id_valid  || (id_ready_go && ex_allowin);

    assign if_to_id_fire  = if_valid  && if_ready_go  && id_allowin;
    assign id_to_ex_fire  = id_valid  && id_ready_go  && ex_allowin;
    assign ex_to_mem_fire = ex_valid  && ex_ready_go  && mem_allowin;
    assign mem_to_wb_fire = mem_valid && mem_ready_go;

    assign br_fire     = id_to_ex_fire && br_taken;
    assign flush_if    = br_fire;
    assign stall_cycle = load_use_stall || (ex_valid && ex_busy);

    // Fetch PC: a redirect wins over sequential advance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc <= RESET_PC;
        end else if (br_fire) begin
            pc <= {br_target[XLEN-1:2], 2'b00};
        end else if (if_to_id_fire) begin
            pc <= pc + XLEN'(4);
        end
    end

    // Stage valid bits; a redirect kills whatever IF hands to ID this cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            if_valid  <= 1'b0;
            id_valid  <= 1'b0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
        end else begin
            if_valid <= 1'b1;
            if (br_fire) begin
                id_valid <= 1'b0;
            end else if (id_allowin) begin
                id_valid <= if_to_id_fire;
            end
            if (ex_allowin) begin
                ex_valid <= id_to_ex_fire;
            end
            if (mem_allowin) begin
                mem_valid <= ex_to_mem_fire;
            end
            wb_valid <= mem_to_wb_fire;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (stall_cycle) begin
            stall_cnt <= stall_cnt + XLEN'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random traffic, every cycle compared
// against a stage-occupancy model of the handshake rules.
module tb_pipe_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_ready_go, mem_ready_go, ex_busy;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_is_load, br_taken;
    logic [31:0] br_target;
    logic [31:0] pc, stall_cnt;
    logic        if_valid, id_valid, ex_valid, mem_valid, wb_valid;
    logic        if_to_id_fire, id_to_ex_fire, ex_to_mem_fire, mem_to_wb_fire;
    logic        flush_if, load_use_stall;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .resetn(resetn),
        .if_ready_go(if_ready_go), .mem_ready_go(mem_ready_go), .ex_busy(ex_busy),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .br_taken(br_taken), .br_target(br_target),
        .pc(pc), .if_valid(if_valid), .id_valid(id_valid), .ex_valid(ex_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid),
        .if_to_id_fire(if_to_id_fire), .id_to_ex_fire(id_to_ex_fire),
        .ex_to_mem_fire(ex_to_mem_fire), .mem_to_wb_fire(mem_to_wb_fire),
        .flush_if(flush_if), .load_use_stall(load_use_stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Model: occupancy of stages 0..4 (IF..WB), fetch pc and stall count.
    bit          mv[5];
    logic [31:0] mpc;
    logic [31:0] mcnt;
    bit          e_rg[4];
    bit          e_al[5];
    bit          e_fire[4];
    bit          e_lus, e_br;

    task automatic model_reset();
        for (int s = 0; s < 5; s++) mv[s] = 1'b0;
        mpc  = RST_PC;
        mcnt = 32'd0;
    endtask

    task automatic model_eval();
        e_lus = mv[1] && mv[2] && ex_is_load && (ex_rd != 5'd0) &&
                ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        e_rg[0] = if_ready_go;
        e_rg[1] = !e_lus;
        e_rg[2] = !ex_busy;
        e_rg[3] = mem_ready_go;
        e_al[4] = 1'b1;
        for (int s = 3; s >= 0; s--) begin
            e_al[s]   = !mv[s] || (e_rg[s] && e_al[s+1]);
            e_fire[s] = mv[s] && e_rg[s] && e_al[s+1];
        end
        e_br = e_fire[1] && br_taken;
    endtask

    task automatic model_step();
        bit nv[5];
        model_eval();
        if (!resetn) begin
            model_reset();
            return;
        end
        for (int s = 1; s < 5; s++) nv[s] = e_al[s] ? e_fire[s-1] : mv[s];
        nv[0] = 1'b1;
        if (e_br) nv[1] = 1'b0;
        if (e_lus || (mv[2] && ex_busy)) mcnt = mcnt + 32'd1;
        if (e_br)           mpc = {br_target[31:2], 2'b00};
        else if (e_fire[0]) mpc = mpc + 32'd4;
        for (int s = 0; s < 5; s++) mv[s] = nv[s];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        model_eval();
        check("pc", pc, mpc);
        check("stall_cnt", stall_cnt, mcnt);
        check("if_valid", 32'(if_valid), 32'(mv[0]));
        check("id_valid", 32'(id_valid), 32'(mv[1]));
        check("ex_valid", 32'(ex_valid), 32'(mv[2]));
        check("mem_valid", 32'(mem_valid), 32'(mv[3]));
        check("wb_valid", 32'(wb_valid), 32'(mv[4]));
        check("if_to_id_fire", 32'(if_to_id_fire), 32'(e_fire[0]));
        check("id_to_ex_fire", 32'(id_to_ex_fire), 32'(e_fire[1]));
        check("ex_to_mem_fire", 32'(ex_to_mem_fire), 32'(e_fire[2]));
        check("mem_to_wb_fire", 32'(mem_to_wb_fire), 32'(e_fire[3]));
        check("flush_if", 32'(flush_if), 32'(e_br));
        check("load_use_stall", 32'(load_use_stall), 32'(e_lus));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        if_ready_go = 1'b1; mem_ready_go = 1'b1; ex_busy = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_is_load = 1'b0; ex_rd = 5'd0; br_taken = 1'b0; br_target = 32'd0;
    endtask

    logic [31:0] save_pc, save_cnt;

    initial begin
        resetn = 1'b0;
        quiet_inputs();
        model_reset();
        @(negedge clk);
        tick();
        tick();
        check("reset_pc", pc, RST_PC);
        check("reset_if_valid", 32'(if_valid), 32'd0);

        // Release with no hazards: pc advances by 4, WB fills on the 5th edge.
        resetn = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            check("fill_pc", pc, RST_PC + 32'(4 * (n - 1)));
            check("fill_wb_valid", 32'(wb_valid), 32'(n >= 5));
        end

        // Load-use hazard on rs1: one stall cycle, one bubble.
        ex_is_load = 1'b1; ex_rd = 5'd5; id_use_rs1 = 1'b1; id_rs1 = 5'd5;
        #1;
        check("lu_stall_on", 32'(load_use_stall), 32'd1);
        save_pc = mpc; save_cnt = mcnt;
        tick();
        check("lu_bubble", 32'(ex_valid), 32'd0);
        check("lu_stall_off", 32'(load_use_stall), 32'd0);
        check("lu_pc_hold", pc, save_pc);
        check("lu_cnt", stall_cnt, save_cnt + 32'd1);
        quiet_inputs();
        tick();
        tick();

        // Destination x0 never interlocks.
        ex_is_load = 1'b1; ex_rd = 5'd0; id_use_rs1 = 1'b1; id_rs1 = 5'd0;
        #1;
        check("x0_no_stall", 32'(load_use_stall), 32'd0);
        tick();
        check("x0_no_bubble", 32'(ex_valid), 32'd1);
        quiet_inputs();
        tick();

        // Branch while fetch is not ready: redirect, flush, aligned target.
        if_ready_go = 1'b0; br_taken = 1'b1; br_target = 32'h8000_0103;
        #1;
        check("br_flush", 32'(flush_if), 32'd1);
        tick();
        check("br_pc", pc, 32'h8000_0100);
        check("br_id_kill", 32'(id_valid), 32'd0);
        br_taken = 1'b0;
        #1;
        check("br_flush_end", 32'(flush_if), 32'd0);
        quiet_inputs();
        tick(); tick(); tick();

        // EX busy holds a pending branch for three cycles.
        ex_busy = 1'b1; br_taken = 1'b1; br_target = 32'h8000_0200;
        save_pc = mpc; save_cnt = mcnt;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("busy_no_flush", 32'(flush_if), 32'd0);
            tick();
            check("busy_pc_hold", pc, save_pc);
            check("busy_id_hold", 32'(id_valid), 32'd1);
        end
        check("busy_cnt", stall_cnt, save_cnt + 32'd3);
        ex_busy = 1'b0;
        #1;
        check("busy_release_flush", 32'(flush_if), 32'd1);
        tick();
        check("busy_br_pc", pc, 32'h8000_0200);
        quiet_inputs();
        tick(); tick();

        // PC wraps at the top of the address space.
        br_taken = 1'b1; br_target = 32'hFFFF_FFFE;
        tick();
        check("wrap_pre", pc, 32'hFFFF_FFFC);
        br_taken = 1'b0;
        tick();
        check("wrap_pc", pc, 32'h0000_0000);
        tick(); tick(); tick();

        // Asynchronous reset mid-stream clears state without a clock edge.
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("async_pc", pc, RST_PC);
        check("async_valids", 32'({if_valid, id_valid, ex_valid, mem_valid, wb_valid}), 32'd0);
        check("async_fires", 32'({if_to_id_fire, id_to_ex_fire, ex_to_mem_fire, mem_to_wb_fire}), 32'd0);
        check("async_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        tick();
        resetn = 1'b1;
        tick();

        // Random traffic against the model, with occasional resets.
        for (int c = 0; c < 600; c++) begin
            resetn       = ($urandom_range(0, 99) != 0);
            if_ready_go  = ($urandom_range(0, 3) != 0);
            mem_ready_go = ($urandom_range(0, 3) != 0);
            ex_busy      = ($urandom_range(0, 4) == 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            ex_is_load   = 1'($urandom_range(0, 1));
            ex_rd        = 5'($urandom_range(0, 3));
            br_taken     = ($urandom_range(0, 5) == 0);
            br_target    = $urandom;
            if (!resetn) begin
                #1;
                model_reset();
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h8000_0000, giving the PC value held in reset.
REQ-002 The ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- if_ready_go  in  1  fetch data for the current PC is available.
- mem_ready_go  in  1  MEM stage access is complete.
- ex_busy  in  1  the EX multi-cycle unit is still running.
- id_rs1, id_rs2  in  5 each  ID source register indices.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction reads that source.
- ex_is_load  in  1  the EX instruction is a load.
- ex_rd  in  5  EX destination register.
- br_taken  in  1  the ID instruction redirects control flow.
- br_target  in  32  redirect address.
- pc  out  32  current fetch PC.
- if_valid, id_valid, ex_valid, mem_valid, wb_valid  out  1 each  stage holds a live instruction.
- if_to_id_fire, id_to_ex_fire, ex_to_mem_fire, mem_to_wb_fire  out  1 each  stage-to-stage transfer this cycle.
- flush_if  out  1  cancel the in-flight fetch.
- load_use_stall  out  1  ID is held by a load-use hazard.
- stall_cnt  out  32  count of stall cycles.

Function
REQ-003 Each stage's ready_go SHALL be:
- IF = if_ready_go
- ID = !load_use_stall
- EX = !ex_busy
- MEM = mem_ready_go
- WB = 1
REQ-004 Each allowin SHALL be combinational: allowin_s = !valid_s || (ready_go_s && allowin_next); WB allowin = 1.
REQ-005 The fire signal X_to_Y_fire SHALL equal valid_X && ready_go_X && allowin_Y (combinational).
REQ-006 Each valid bit for ID, EX, MEM and WB SHALL update only when its allowin is 1: valid_s <= fire from the previous stage; otherwise it holds.
REQ-007 if_valid SHALL be 0 in reset, become 1 on the first rising edge after resetn deasserts, and stay 1.
REQ-008 load_use_stall SHALL be combinational = id_valid && ex_valid && ex_is_load && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)).
REQ-009 Hazards against MEM and WB SHALL be left to forwarding; no other interlock exists.
REQ-010 br_fire SHALL be id_to_ex_fire && br_taken; flush_if SHALL equal br_fire (combinational).
REQ-011 On br_fire, the next cycle SHALL have:
- pc <= {br_target[31:2], 2'b00}, regardless of if_ready_go;
- id_valid <= 0, overriding REQ-006.
REQ-012 Otherwise, on if_to_id_fire, pc SHALL become pc + 4, wrapping modulo 2^32; otherwise pc holds.
REQ-013 A branch and a load-use stall SHALL NOT both act in one cycle; because REQ-003 sets ID ready_go low, br_fire is impossible during load_use_stall.
REQ-014 ex_busy with a pending branch SHALL delay br_fire until ex_allowin = 1; the ID instruction and pc hold meanwhile.
REQ-015 stall_cnt SHALL increment by 1 on each cycle with (load_use_stall || (ex_valid && ex_busy)), wrapping from 32'hFFFF_FFFF to 0.
REQ-016 All pipeline registers SHALL be pc, the five valid bits and stall_cnt; every other output SHALL be combinational.

Reset
REQ-017 When resetn is low, the block SHALL immediately set pc = RESET_PC, all valid bits = 0 and stall_cnt = 0, independent of clk.
REQ-018 Assertion of resetn mid-operation SHALL discard all in-flight instructions, with no fire pulses once the registers clear.
REQ-019 The fire outputs, flush_if and load_use_stall SHALL be 0 while in reset.

Verification
REQ-020 Reset release, all ready_go = 1, no hazards -> pc steps 8000_0000, 8000_0004, …; wb_valid first 1 on the 5th edge after release.
REQ-021 Load in EX with ex_rd = 5, ID with id_use_rs1 = 1 and id_rs1 = 5 -> load_use_stall = 1 for exactly 1 cycle; ex_valid = 0 the next cycle (bubble); pc holds; stall_cnt += 1.
REQ-022 Same as REQ-021 but ex_rd = 0 -> load_use_stall stays 0, no bubble.
REQ-023 br_taken = 1 with br_target = 32'h8000_0103 while if_ready_go = 0 -> flush_if pulses 1 cycle; pc = 8000_0100 next cycle; id_valid = 0 next cycle.
REQ-024 ex_busy held 3 cycles with a branch in ID -> br_fire delayed 3 cycles; stall_cnt += 3; id_valid and pc unchanged during the wait.
REQ-025 pc = FFFF_FFFC with a fetch fire -> pc = 0000_0000; resetn pulsed low mid-stream -> all valid bits 0 and pc = RESET_PC without a clock edge.
